// File: rtl/axi4l_pkg.sv
// rtl/axi4l_pkg.sv - AXI4-Lite shared types: address/data, response codes, protection bits
package axi4l_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef logic [ADDR_W-1:0]   addr_t;
  typedef logic [DATA_W-1:0]   data_t;
  typedef logic [DATA_W/8-1:0] strb_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef logic [2:0] prot_t;
  localparam prot_t PROT_PRIV  = 3'b001;
  localparam prot_t PROT_NSEC  = 3'b010;
  localparam prot_t PROT_INSTR = 3'b100;
endpackage

// File: rtl/axi4l_if.sv
// rtl/axi4l_if.sv - AXI4-Lite bus bundle with master/slave views
interface axi4l_if (
  input logic aclk,
  input logic aresetn
);
  import axi4l_pkg::*;

  addr_t awaddr;
  prot_t awprot;
  logic  awvalid;
  logic  awready;
  data_t wdata;
  strb_t wstrb;
  logic  wvalid;
  logic  wready;
  resp_t bresp;
  logic  bvalid;
  logic  bready;
  addr_t araddr;
  prot_t arprot;
  logic  arvalid;
  logic  arready;
  data_t rdata;
  resp_t rresp;
  logic  rvalid;
  logic  rready;

  modport master (
    input  aclk, aresetn,
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  aclk, aresetn,
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/ibex_obi_axi4l_bridge.sv
// rtl/ibex_obi_axi4l_bridge.sv - single-outstanding Ibex req/gnt/rvalid to AXI4-Lite master bridge
// Optional IBEX_AXI4L_BRIDGE_PROT_EN adds priv_i, driven onto axprot[0].
module ibex_obi_axi4l_bridge
  import axi4l_pkg::*;
#(
  parameter int INSTR_PORT = 0,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [31:0]           wdata_i,
  output logic                  rvalid_o,
  output logic [31:0]           rdata_o,
  output logic                  err_o,
`ifdef IBEX_AXI4L_BRIDGE_PROT_EN
  input  logic                  priv_i,
`endif
  axi4l_if.master               axi
);

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);
  localparam prot_t PROT_BASE = (INSTR_PORT != 0) ? PROT_INSTR : prot_t'(0);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [3:0]              be_q;
  logic [31:0]             wdata_q;
  logic                    awvalid_q, wvalid_q, arvalid_q, bready_q, rready_q;
  logic                    aw_done, w_done;
  logic                    aw_hs, w_hs, aw_ok, w_ok;
  prot_t                   prot;

`ifdef IBEX_AXI4L_BRIDGE_PROT_EN
  logic priv_q;
  assign prot = PROT_BASE | (priv_q ? PROT_PRIV : prot_t'(0));
`else
  assign prot = PROT_BASE;
`endif

  // Grant is only offered from IDLE, which keeps at most one transaction in flight.
  assign gnt_o = aresetn && req_i && (state == IDLE);

  assign aw_hs = awvalid_q && axi.awready;
  assign w_hs  = wvalid_q && axi.wready;
  assign aw_ok = aw_done || aw_hs;
  assign w_ok  = w_done || w_hs;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state     <= IDLE;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      rvalid_o  <= 1'b0;
      rdata_o   <= '0;
      err_o     <= 1'b0;
`ifdef IBEX_AXI4L_BRIDGE_PROT_EN
      priv_q    <= 1'b0;
`endif
    end else begin
      rvalid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_o) begin
            addr_q    <= addr_i & WORD_MASK;
            be_q      <= be_i;
            wdata_q   <= wdata_i;
            awvalid_q <= we_i;
            wvalid_q  <= we_i;
            arvalid_q <= !we_i;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
`ifdef IBEX_AXI4L_BRIDGE_PROT_EN
            priv_q    <= priv_i;
`endif
            state     <= we_i ? WR_REQ : RD_REQ;
          end
        end
        WR_REQ: begin
          // AW and W retire independently; B is only accepted once both have.
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done   <= 1'b1;
          end
          if (aw_ok && w_ok) begin
            bready_q <= 1'b1;
            state    <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (axi.bvalid) begin
            bready_q <= 1'b0;
            rvalid_o <= 1'b1;
            err_o    <= (axi.bresp != OKAY);
            state    <= IDLE;
          end
        end
        RD_REQ: begin
          if (axi.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (axi.rvalid) begin
            rready_q <= 1'b0;
            rvalid_o <= 1'b1;
            rdata_o  <= axi.rdata;
            err_o    <= (axi.rresp != OKAY);
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign axi.awaddr  = addr_q;
  assign axi.awprot  = prot;
  assign axi.awvalid = awvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = be_q;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = bready_q;
  assign axi.araddr  = addr_q;
  assign axi.arprot  = prot;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;

endmodule

// File: tb/tb_ibex_obi_axi4l_bridge.sv
// tb/tb_ibex_obi_axi4l_bridge.sv - scoreboard bench for ibex_obi_axi4l_bridge with an AXI4-Lite RAM slave model
module tb_ibex_obi_axi4l_bridge;
  import axi4l_pkg::*;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        req_i = 1'b0;
  logic        gnt_o;
  logic [31:0] addr_i = '0;
  logic        we_i = 1'b0;
  logic [3:0]  be_i = '0;
  logic [31:0] wdata_i = '0;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
`ifdef IBEX_AXI4L_BRIDGE_PROT_EN
  logic        priv_i = 1'b0;
`endif

  always #5 aclk = ~aclk;

  axi4l_if bus (.aclk(aclk), .aresetn(aresetn));

  ibex_obi_axi4l_bridge #(.INSTR_PORT(0), .ADDR_WIDTH(32)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i), .we_i(we_i),
    .be_i(be_i), .wdata_i(wdata_i),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
`ifdef IBEX_AXI4L_BRIDGE_PROT_EN
    .priv_i(priv_i),
`endif
    .axi(bus)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  always @(posedge aclk) cyc <= cyc + 1;

  // RAM slave model with programmable AW/W ready delays and an optional R hold-off.
  logic [31:0] mem [0:255];
  int          aw_delay = 0, w_delay = 0, aw_wait = 0, w_wait = 0;
  bit          r_hold = 1'b0;
  logic        aw_got, w_got, r_pend;
  logic [31:0] aw_addr_q, w_data_q;
  logic [3:0]  w_strb_q;

  assign bus.awready = (aw_wait >= aw_delay) && !aw_got && !bus.bvalid;
  assign bus.wready  = (w_wait >= w_delay) && !w_got && !bus.bvalid;
  assign bus.arready = !bus.rvalid && !r_pend;

  always @(posedge aclk) begin
    logic [31:0] a, d;
    logic [3:0]  s;
    logic        awf, wf;
    if (!aresetn) begin
      aw_wait <= 0; w_wait <= 0; aw_got <= 1'b0; w_got <= 1'b0; r_pend <= 1'b0;
      bus.bvalid <= 1'b0; bus.bresp <= OKAY;
      bus.rvalid <= 1'b0; bus.rresp <= OKAY; bus.rdata <= '0;
    end else begin
      awf = bus.awvalid && bus.awready;
      wf  = bus.wvalid && bus.wready;
      if (bus.awvalid && !bus.awready && !aw_got) aw_wait <= aw_wait + 1;
      if (bus.wvalid && !bus.wready && !w_got) w_wait <= w_wait + 1;
      if (awf) begin aw_got <= 1'b1; aw_addr_q <= bus.awaddr; aw_wait <= 0; end
      if (wf) begin w_got <= 1'b1; w_data_q <= bus.wdata; w_strb_q <= bus.wstrb; w_wait <= 0; end
      if ((aw_got || awf) && (w_got || wf)) begin
        a = awf ? bus.awaddr : aw_addr_q;
        d = wf ? bus.wdata : w_data_q;
        s = wf ? bus.wstrb : w_strb_q;
        for (int b = 0; b < 4; b++)
          if (s[b]) mem[a[9:2]][8*b +: 8] <= d[8*b +: 8];
        bus.bvalid <= 1'b1;
        bus.bresp  <= OKAY;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
      if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;
      if (bus.arvalid && bus.arready) begin
        if (r_hold) r_pend <= 1'b1;
        else begin
          bus.rvalid <= 1'b1;
          bus.rdata  <= (bus.araddr == 32'h200) ? 32'h0 : mem[bus.araddr[9:2]];
          bus.rresp  <= (bus.araddr == 32'h200) ? SLVERR : OKAY;
        end
      end
      if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];
  int   n_push = 0, rv_count = 0, last_rv_cyc = 0;

  // Protocol trackers: one transaction in flight, and B only after both AW and W.
  logic busy = 1'b0, aw_seen = 1'b0, w_seen = 1'b0;
  always @(posedge aclk) begin
    if (!aresetn) begin
      busy <= 1'b0; aw_seen <= 1'b0; w_seen <= 1'b0;
    end else begin
      busy <= gnt_o ? 1'b1 : (rvalid_o ? 1'b0 : busy);
      if (bus.bvalid && bus.bready) begin aw_seen <= 1'b0; w_seen <= 1'b0; end
      else begin
        if (bus.awvalid && bus.awready) aw_seen <= 1'b1;
        if (bus.wvalid && bus.wready) w_seen <= 1'b1;
      end
    end
  end

  always @(negedge aclk) begin
    exp_t e;
    if (aresetn) begin
      if (gnt_o) check("gnt_while_busy", 32'(busy && !rvalid_o), 32'h0);
      if (bus.bready) check("bready_before_aw_w", 32'(aw_seen && w_seen), 32'h1);
      if (rvalid_o) begin
        rv_count++;
        last_rv_cyc = cyc;
        if (sb.size() == 0) check("unexpected_rvalid", 32'h1, 32'h0);
        else begin
          e = sb.pop_front();
          check("rsp_err", 32'(err_o), 32'(e.err));
          check("rsp_rdata", rdata_o, e.rdata);
        end
      end
    end
  end

  task automatic do_req(input logic [31:0] a, input logic w, input logic [3:0] be,
                        input logic [31:0] d, input logic [31:0] er, input logic ee,
                        input bit push, output int g);
    bit got = 1'b0;
    g = -1;
    @(posedge aclk); #1;
    req_i = 1'b1; addr_i = a; we_i = w; be_i = be; wdata_i = d;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge aclk);
      if (gnt_o) got = 1'b1;
    end
    if (!got) check("gnt_timeout", 32'h0, 32'h1);
    else begin
      g = cyc;
      if (push) begin sb.push_back('{rdata: er, err: ee}); n_push++; end
    end
    @(posedge aclk); #1;
    req_i = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge aclk);
    if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'h0);
  endtask

  logic [31:0] b2b_addr [4];
  logic [31:0] b2b_data [4];

  initial begin
    int g, k, gprev;
    for (int i = 0; i < 256; i++) mem[i] = '0;

    // Reset state, with req_i high to prove gnt_o stays low
    req_i = 1'b1;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    check("rst_gnt", 32'(gnt_o), 0);
    check("rst_rvalid", 32'(rvalid_o), 0);
    check("rst_err", 32'(err_o), 0);
    check("rst_rdata", rdata_o, 0);
    check("rst_valids", 32'({bus.awvalid, bus.wvalid, bus.arvalid}), 0);
    check("rst_readies", 32'({bus.bready, bus.rready}), 0);
    req_i = 1'b0;
    @(posedge aclk); #1;
    aresetn = 1'b1;

    // Write with an immediately-ready slave
    do_req(32'h10, 1'b1, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, g);
    @(negedge aclk);
    check("wr_awvalid", 32'({bus.awvalid, bus.wvalid}), 32'h3);
    check("wr_awaddr", bus.awaddr, 32'h10);
    check("wr_wdata", bus.wdata, 32'hDEADBEEF);
    check("wr_wstrb", 32'(bus.wstrb), 32'hF);
    check("wr_awprot", 32'(bus.awprot), 32'h0);
    wait_drain();
    check("wr_latency", last_rv_cyc - g, 3);

    // Write with AW held off for three cycles
    aw_delay = 3;
    do_req(32'h30, 1'b1, 4'hF, 32'h0BADF00D, 32'h0, 1'b0, 1'b1, g);
    @(negedge aclk);
    check("split_both_valid", 32'({bus.awvalid, bus.wvalid}), 32'h3);
    @(negedge aclk);
    check("split_w_dropped", 32'({bus.awvalid, bus.wvalid}), 32'h2);
    check("split_addr_stable", bus.awaddr, 32'h30);
    check("split_no_bready", 32'(bus.bready), 0);
    wait_drain();
    check("split_latency", last_rv_cyc - g, 6);
    aw_delay = 0;

    // Read back and error read
    do_req(32'h10, 1'b0, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, g);
    @(negedge aclk);
    check("rd_araddr", bus.araddr, 32'h10);
    check("rd_arprot", 32'(bus.arprot), 32'h0);
    wait_drain();
    check("rd_latency", last_rv_cyc - g, 3);
    do_req(32'h200, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1, 1'b1, g);
    wait_drain();

    // Partial-strobe write, then full write; rdata_o keeps the last read value
    do_req(32'h20, 1'b1, 4'b0011, 32'h12345678, 32'h0, 1'b0, 1'b1, g);
    do_req(32'h24, 1'b1, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1, g);
    wait_drain();

    // Back-to-back reads with req_i held high
    b2b_addr[0] = 32'h20; b2b_data[0] = 32'h00005678;
    b2b_addr[1] = 32'h24; b2b_data[1] = 32'hCAFEF00D;
    b2b_addr[2] = 32'h30; b2b_data[2] = 32'h0BADF00D;
    b2b_addr[3] = 32'h13; b2b_data[3] = 32'hDEADBEEF;
    @(posedge aclk); #1;
    req_i = 1'b1; we_i = 1'b0; addr_i = b2b_addr[0];
    k = 0; gprev = 0;
    for (int i = 0; i < 60 && k < 4; i++) begin
      @(negedge aclk);
      if (gnt_o) begin
        sb.push_back('{rdata: b2b_data[k], err: 1'b0});
        n_push++;
        if (k > 0) check("b2b_gap", cyc - gprev, 3);
        gprev = cyc;
        k++;
        @(posedge aclk); #1;
        if (k < 4) addr_i = b2b_addr[k];
        else req_i = 1'b0;
      end
    end
    check("b2b_grants", k, 4);
    wait_drain();
    repeat (3) @(negedge aclk);

    // Reset while waiting in RD_RESP; the pending response must vanish
    r_hold = 1'b1;
    do_req(32'h10, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, 1'b0, g);
    @(negedge aclk);
    @(negedge aclk);
    check("pre_rst_rready", 32'(bus.rready), 32'h1);
    @(posedge aclk); #1;
    aresetn = 1'b0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    r_hold = 1'b0;
    @(negedge aclk);
    check("post_rst_idle", 32'({bus.arvalid, bus.rready, rvalid_o}), 32'h0);
    check("post_rst_rdata", rdata_o, 32'h0);
    repeat (3) @(negedge aclk);
    do_req(32'h24, 1'b0, 4'hF, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1, g);
    wait_drain();
    repeat (4) @(negedge aclk);
    check("rvalid_count", rv_count, n_push);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout want finish");
    $fatal(1);
  end
endmodule
